universal_shift_register_seq: RTL and testbench

//  Parametrised, command-driven universal shift register; successor to the fixed 8-bit shifter.

---
 rtl/usr_pkg.sv | 27 ++
 rtl/usr_step_unit.sv | 46 ++++
 rtl/universal_shift_register_seq.sv | 120 ++++++++++++
 tb/tb_universal_shift_register_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
// Op codes, FSM states and an op classification helper.
package usr_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_CLEAR = 3'd2,
    OP_SHL   = 3'd3,
    OP_SHR   = 3'd4,
    OP_ASR   = 3'd5,
    OP_ROL   = 3'd6,
    OP_ROR   = 3'd7
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift(input op_t op);
    return op >= OP_SHL;
  endfunction

endpackage

// File: rtl/usr_step_unit.sv
// One-position shift/rotate step.
// Non-shift ops pass data through unchanged.
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  op_t              op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] d_next,
  output logic             bit_out
);

  always_comb begin
    d_next  = d;
    bit_out = 1'b0;
    unique case (op)
      OP_SHL: begin
        d_next  = {d[WIDTH-2:0], ser_in};
        bit_out = d[WIDTH-1];
      end
      OP_SHR: begin
        d_next  = {ser_in, d[WIDTH-1:1]};
        bit_out = d[0];
      end
      OP_ASR: begin
        d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
        bit_out = d[0];
      end
      OP_ROL: begin
        d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
        bit_out = d[WIDTH-1];
      end
      OP_ROR: begin
        d_next  = {d[0], d[WIDTH-1:1]};
        bit_out = d[0];
      end
      default: begin
        d_next  = d;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_register_seq.sv
// Command-driven universal shift register.
// Multi-step shifts run one position per clock.
module universal_shift_register_seq
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amount,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             done,
  output logic             busy
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;

  op_t              cmd_op_t;
  op_t              step_op;
  logic [WIDTH-1:0] step_d;
  logic             step_bit;

  assign cmd_op_t = op_t'(cmd_op);
  assign step_op  = (state_q == SHIFT) ? op_q : cmd_op_t;

  usr_step_unit #(.WIDTH(WIDTH)) u_step (
    .d       (data_q),
    .op      (step_op),
    .ser_in  (ser_in),
    .d_next  (step_d),
    .bit_out (step_bit)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          done_d = 1'b1;
          op_d   = cmd_op_t;
          unique case (1'b1)
            (cmd_op_t == OP_LOAD):  data_d = cmd_data;
            (cmd_op_t == OP_CLEAR): data_d = '0;
            is_shift(cmd_op_t): begin
              if (cmd_amount != '0) begin
                data_d = step_d;
                ser_d  = step_bit;
              end
              if (cmd_amount > AMT_W'(1)) begin
                state_d = SHIFT;
                cnt_d   = cmd_amount - AMT_W'(1);
                done_d  = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      SHIFT: begin
        // abort wins over the final step
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          data_d = step_d;
          ser_d  = step_bit;
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign cmd_ready = ~busy;
  assign data_out  = data_q;
  assign ser_out   = ser_q;
  assign done      = done_q;

endmodule

// File: tb/tb_universal_shift_register_seq.sv
// Scoreboard bench for universal_shift_register_seq.
// Expected results queued at issue, checked on done.
module tb_universal_shift_register_seq;

  localparam int W = 8;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [A-1:0] cmd_amount;
  logic [W-1:0] cmd_data;
  logic         ser_in;
  logic         abort;
  logic [W-1:0] data_out;
  logic         ser_out;
  logic         done;
  logic         busy;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
    bit           cs;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   busy_cyc = 0;

  universal_shift_register_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_amount (cmd_amount),
    .cmd_data   (cmd_data),
    .ser_in     (ser_in),
    .abort      (abort),
    .data_out   (data_out),
    .ser_out    (ser_out),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data", 32'(data_out), 32'(e.d));
        if (e.cs) check("ser", 32'(ser_out), 32'(e.s));
      end
    end
  end

  task automatic push(input logic [W-1:0] d, input logic s,
                      input bit cs);
    exp_t e;
    e.d = d; e.s = s; e.cs = cs;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input int amt,
                       input logic [W-1:0] d);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_amount = A'(amt);
    cmd_data   = d;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk); t++;
    end
    check("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rot(input logic [W-1:0] d,
                                       input int n, input bit left);
    logic [2*W-1:0] t;
    int k;
    t = {d, d};
    k = n % W;
    if (left) return t[2*W-1-k -: W];
    return t[W-1+k -: W];
  endfunction

  initial begin
    int d0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_amount = '0; cmd_data = '0; ser_in = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 32'(data_out), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // reset mid-shift
    issue(3'd1, 0, 8'hFF); push(8'hFF, 1'b0, 1'b0);
    drain();
    issue(3'd3, 6, 8'h00);
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 1);
    reset = 1'b0; #1;
    check("mr_data", 32'(data_out), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    check("mr_ser", 32'(ser_out), 0);
    #3 reset = 1'b1;
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("mr_no_done", done_cnt, d0);
    check("mr_ready", 32'(cmd_ready), 1);

    // LOAD A5, ROL 3
    issue(3'd1, 0, 8'hA5); push(8'hA5, 1'b0, 1'b0);
    drain();
    busy_cyc = 0; d0 = done_cnt;
    issue(3'd6, 3, 8'h00); push(8'h2D, 1'b1, 1'b1);
    drain();
    check("rol3_busy", busy_cyc, 2);
    check("rol3_done", done_cnt - d0, 1);

    // ASR and SHR
    issue(3'd1, 0, 8'h81); push(8'h81, 1'b0, 1'b0);
    issue(3'd5, 2, 8'h00); push(8'hE0, 1'b0, 1'b1);
    ser_in = 1'b1;
    issue(3'd4, 2, 8'h00); push(8'hF8, 1'b0, 1'b1);
    drain();
    ser_in = 1'b0;

    // SHL N=0 and N=1
    busy_cyc = 0;
    issue(3'd1, 0, 8'h01); push(8'h01, 1'b0, 1'b0);
    issue(3'd3, 0, 8'h00); push(8'h01, 1'b0, 1'b0);
    check("n0_done", 32'(done), 1);
    issue(3'd3, 1, 8'h00); push(8'h02, 1'b0, 1'b1);
    check("n1_done", 32'(done), 1);
    drain();
    check("n01_busy", busy_cyc, 0);

    // ROR 5 with abort after second step
    issue(3'd1, 0, 8'h01); push(8'h01, 1'b0, 1'b0);
    drain();
    d0 = done_cnt;
    issue(3'd7, 5, 8'h00); push(8'h40, 1'b0, 1'b1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_ready", 32'(cmd_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_done", done_cnt - d0, 1);
    check("abort_data", 32'(data_out), 32'h40);

    // ROL 9 equals ROL 1
    issue(3'd1, 0, 8'h96); push(8'h96, 1'b0, 1'b0);
    issue(3'd6, 9, 8'h00); push(8'h2D, 1'b1, 1'b1);
    drain();

    // back-to-back: LOAD in the done cycle
    issue(3'd6, 2, 8'h00); push(8'hB4, 1'b0, 1'b1);
    begin
      int t = 0;
      while (!done && t < 20) begin
        @(posedge clk); #1; t++;
      end
      check("b2b_wait", 32'(done), 1);
    end
    check("b2b_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h3C;
    push(8'h3C, 1'b0, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_done", 32'(done), 1);
    drain();

    // commands while busy are dropped
    d0 = done_cnt;
    issue(3'd6, 4, 8'h00); push(8'hC3, 1'b1, 1'b1);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("busy_drop", done_cnt - d0, 1);

    // random rotates against a wrap model
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] v, r;
      int  n;
      bit  left;
      v = W'($urandom);
      n = $urandom_range(1, 15);
      left = 1'($urandom);
      r = rot(v, n, left);
      issue(3'd1, 0, v); push(v, 1'b0, 1'b0);
      issue(left ? 3'd6 : 3'd7, n, 8'h00);
      push(r, left ? r[0] : r[W-1], 1'b1);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
